// File: rtl/scan_rate_ctrl.sv
// scan_rate_ctrl: steps the LED ROM read address at a button-selectable rate.
// Three active-low pushbuttons are synchronised and debounced. Each stable
// press produces a one-cycle event that toggles pause or moves the speed
// level. A period counter divides the clock by BASE_PERIOD >> speed_lvl,
// and the address advances by one at the end of each period.
module scan_rate_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ADDR_LAST   = 255,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned DB_CYCLES   = 250_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_p,
  input  logic              btn_spdup,
  input  logic              btn_spddn,
  output logic [ADDR_W-1:0] addr,
  output logic              tick,
  output logic              paused,
  output logic [1:0]        speed_lvl
);

  // Debounce counter value at which a persistent difference is accepted.
  localparam logic [31:0]       DB_LAST     = 32'(DB_CYCLES - 1);
  localparam logic [31:0]       BASE_P      = 32'(BASE_PERIOD);
  localparam logic [ADDR_W-1:0] ADDR_LAST_V = ADDR_W'(ADDR_LAST);

  // Bit 0 = pause, bit 1 = speed-up, bit 2 = speed-down.
  logic [2:0] btn_raw;
  logic [2:0] press_ev;

  assign btn_raw = {btn_spddn, btn_spdup, btn_p};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic        sync1_q;
      logic        sync2_q;
      logic        stable_q;
      logic        press_q;
      logic [31:0] db_cnt_q;
      logic        settle;

      // The synced level has differed from the stable state long enough.
      assign settle = (sync2_q != stable_q) && (db_cnt_q == DB_LAST);

      // Synchronise, debounce and turn a stable 1->0 edge into a pulse.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_q  <= 1'b1;
          sync2_q  <= 1'b1;
          stable_q <= 1'b1;
          press_q  <= 1'b0;
          db_cnt_q <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          // Only a settled transition to the pressed (low) level is an event.
          press_q <= settle && !sync2_q;
          if (sync2_q == stable_q) begin
            db_cnt_q <= '0;
          end else if (settle) begin
            stable_q <= sync2_q;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 32'd1;
          end
        end
      end

      assign press_ev[gi] = press_q;
    end
  endgenerate

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick_q, tick_d;
  logic              paused_q, paused_d;
  logic [1:0]        speed_q, speed_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       period;
  logic              terminal;
  logic              lvl_chg;
  logic              up_ev;
  logic              dn_ev;

  // Next-state logic for speed, pause, period counter and address.
  always_comb begin
    // Opposing speed events in the same cycle cancel each other.
    up_ev    = press_ev[1] && !press_ev[2];
    dn_ev    = press_ev[2] && !press_ev[1];
    speed_d  = speed_q;
    lvl_chg  = 1'b0;
    if (up_ev && (speed_q != 2'd3)) begin
      speed_d = speed_q + 2'd1;
      lvl_chg = 1'b1;
    end else if (dn_ev && (speed_q != 2'd0)) begin
      speed_d = speed_q - 2'd1;
      lvl_chg = 1'b1;
    end

    period   = BASE_P >> speed_q;
    // Terminal count uses the pre-toggle pause flag, so a pause arriving on
    // the last count still lets this advance happen.
    terminal = !paused_q && (cnt_q == (period - 32'd1));

    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (terminal) begin
      cnt_d  = '0;
      addr_d = (addr_q == ADDR_LAST_V) ? '0 : addr_q + ADDR_W'(1);
    end else if (lvl_chg) begin
      // A real level change restarts the period; saturated presses do not.
      cnt_d = '0;
    end else if (!paused_q) begin
      cnt_d = cnt_q + 32'd1;
    end

    tick_d   = terminal;
    paused_d = paused_q ^ press_ev[0];
  end

  // Register all sequencer state; outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
      speed_q  <= 2'd1;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign addr      = addr_q;
  assign tick      = tick_q;
  assign paused    = paused_q;
  assign speed_lvl = speed_q;

endmodule

// File: tb/tb_scan_rate_ctrl.sv
// Directed bench for scan_rate_ctrl: reset, wrap, pause/resume, speed
// saturation, debounce glitch/bounce, simultaneous buttons and reset.
module tb_scan_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_w_n = 1'b0;
  logic       btn_p = 1'b1;
  logic       btn_spdup = 1'b1;
  logic       btn_spddn = 1'b1;
  logic [7:0] addr, addr_w;
  logic       tick, tick_w;
  logic       paused, paused_w;
  logic [1:0] speed_lvl, speed_w;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_rate_ctrl #(.ADDR_W(8), .ADDR_LAST(255), .BASE_PERIOD(64), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_p(btn_p), .btn_spdup(btn_spdup), .btn_spddn(btn_spddn),
    .addr(addr), .tick(tick), .paused(paused), .speed_lvl(speed_lvl)
  );

  scan_rate_ctrl #(.ADDR_W(8), .ADDR_LAST(3), .BASE_PERIOD(64), .DB_CYCLES(4)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .btn_p(1'b1), .btn_spdup(1'b1), .btn_spddn(1'b1),
    .addr(addr_w), .tick(tick_w), .paused(paused_w), .speed_lvl(speed_w)
  );

  // Count falling edges until tick is seen; -1 if the budget runs out.
  task automatic wait_tick(input bit sel_w, input int max, output int waited);
    waited = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if ((sel_w ? tick_w : tick) === 1'b1) begin
        waited = k;
        break;
      end
    end
  endtask

  // Hold a button (0 pause, 1 up, 2 down, 3 up+down) low, then let it settle.
  task automatic press_btn(input int which, input int n);
    if (which == 0) btn_p = 1'b0;
    if (which == 1 || which == 3) btn_spdup = 1'b0;
    if (which == 2 || which == 3) btn_spddn = 1'b0;
    repeat (n) @(negedge clk);
    btn_p = 1'b1; btn_spdup = 1'b1; btn_spddn = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", addr); end
    n_checks++; if (speed_lvl !== 2'd1) begin n_fail++; $display("FAIL rst_speed got=%0d exp=1", speed_lvl); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL rst_paused got=%0b exp=0", paused); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%0b exp=0", tick); end
    rst_n = 1'b1;
    wait_tick(0, 100, w);
    n_checks++; if (w != 32) begin n_fail++; $display("FAIL rst_first_tick got=%0d exp=32", w); end
    n_checks++; if (addr !== 8'd1) begin n_fail++; $display("FAIL rst_first_addr got=%0d exp=1", addr); end
    wait_tick(0, 100, w);
    n_checks++; if (w != 32) begin n_fail++; $display("FAIL rst_second_tick got=%0d exp=32", w); end
    n_checks++; if (addr !== 8'd2) begin n_fail++; $display("FAIL rst_second_addr got=%0d exp=2", addr); end
    $display("reset: first ticks seen, addr=%0d", addr);
  endtask

  task automatic test_wrap();
    int w;
    bit found;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++; if (addr_w !== 8'd0) begin n_fail++; $display("FAIL wrap_start got=%0d exp=0", addr_w); end
    rst_w_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_tick(1, 100, w);
      n_checks++;
      if (w != 32 || addr_w !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL wrap_small[%0d] got addr=%0d wait=%0d exp addr=%0d wait=32", i, addr_w, w, exp_seq[i]);
      end
      $display("wrap small: tick %0d addr=%0d", i, addr_w);
    end
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wait_tick(0, 40, w);
      if (w < 0) break;
      if (addr == 8'd255) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wrap255_reach got=%0d exp=255", addr); end
    wait_tick(0, 40, w);
    n_checks++; if (w != 32 || addr !== 8'd0) begin n_fail++; $display("FAIL wrap255_to0 got addr=%0d wait=%0d exp addr=0 wait=32", addr, w); end
    $display("wrap 255: addr=%0d", addr);
  endtask

  task automatic test_pause();
    int w;
    int ticks;
    int t;
    logic [7:0] a0;
    wait_tick(0, 40, w);
    // Counter is 0 this cycle; pausing 21 edges later leaves 11 counts.
    repeat (14) @(negedge clk);
    btn_p = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_set got=%0b exp=1", paused); end
    a0 = addr;
    repeat (3) @(negedge clk);
    btn_p = 1'b1;
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0) begin n_fail++; $display("FAIL pause_no_tick got=%0d exp=0", ticks); end
    n_checks++; if (addr !== a0) begin n_fail++; $display("FAIL pause_addr_hold got=%0d exp=%0d", addr, a0); end
    btn_p = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_resume got=%0b exp=0", paused); end
    t = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) btn_p = 1'b1;
      if (tick === 1'b1) begin t = k; break; end
    end
    n_checks++; if (t != 11) begin n_fail++; $display("FAIL pause_remaining got=%0d exp=11", t); end
    n_checks++; if (addr !== a0 + 8'd1) begin n_fail++; $display("FAIL pause_next_addr got=%0d exp=%0d", addr, a0 + 8'd1); end
    $display("pause: resumed, tick after %0d clocks, addr=%0d", t, addr);
  endtask

  task automatic test_speed();
    int lvl_exp [8] = '{2, 3, 3, 2, 1, 0, 0, 0};
    int per_exp [8] = '{16, 8, 8, 16, 32, 64, 64, 64};
    bit chg [8]     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int first;
    int kb;
    int w;
    int lvl_seen;
    int exp_first;
    for (int p = 0; p < 8; p++) begin
      // Each press starts on a tick cycle, so the counter is 0 here.
      if (p < 3) btn_spdup = 1'b0; else btn_spddn = 1'b0;
      first = -1;
      kb = 0;
      lvl_seen = -1;
      for (int k = 1; k <= 150; k++) begin
        @(negedge clk);
        kb = k;
        if (k == 7) lvl_seen = int'(speed_lvl);
        if (k == 10) begin btn_spdup = 1'b1; btn_spddn = 1'b1; end
        if (tick === 1'b1 && first < 0) first = k;
        if (first >= 0 && k >= 10) break;
      end
      btn_spdup = 1'b1; btn_spddn = 1'b1;
      exp_first = chg[p] ? 7 + per_exp[p] : per_exp[p];
      n_checks++; if (lvl_seen != lvl_exp[p]) begin n_fail++; $display("FAIL speed_lvl[%0d] got=%0d exp=%0d", p, lvl_seen, lvl_exp[p]); end
      n_checks++; if (first != exp_first) begin n_fail++; $display("FAIL speed_first_tick[%0d] got=%0d exp=%0d", p, first, exp_first); end
      if (kb != first) wait_tick(0, 100, w);
      wait_tick(0, 100, w);
      n_checks++; if (w != per_exp[p]) begin n_fail++; $display("FAIL speed_spacing[%0d] got=%0d exp=%0d", p, w, per_exp[p]); end
      $display("speed press %0d: lvl=%0d first=%0d spacing=%0d", p, lvl_seen, first, w);
    end
  endtask

  task automatic test_bounce();
    btn_spdup = 1'b0;
    repeat (3) @(negedge clk);
    btn_spdup = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (speed_lvl !== 2'd0) begin n_fail++; $display("FAIL glitch_ignored got=%0d exp=0", speed_lvl); end
    btn_spdup = 1'b0;
    repeat (2) @(negedge clk);
    btn_spdup = 1'b1;
    @(negedge clk);
    btn_spdup = 1'b0;
    repeat (10) @(negedge clk);
    btn_spdup = 1'b1;
    repeat (25) @(negedge clk);
    n_checks++; if (speed_lvl !== 2'd1) begin n_fail++; $display("FAIL bounce_one_event got=%0d exp=1", speed_lvl); end
    $display("bounce: lvl=%0d", speed_lvl);
  endtask

  task automatic test_simul_reset();
    int w;
    press_btn(3, 10);
    n_checks++; if (speed_lvl !== 2'd1) begin n_fail++; $display("FAIL simul_cancel got=%0d exp=1", speed_lvl); end
    press_btn(1, 10);
    press_btn(1, 10);
    n_checks++; if (speed_lvl !== 2'd3) begin n_fail++; $display("FAIL simul_to3 got=%0d exp=3", speed_lvl); end
    press_btn(0, 10);
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL simul_paused got=%0b exp=1", paused); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (addr !== 8'd0) begin n_fail++; $display("FAIL midrst_addr got=%0d exp=0", addr); end
    n_checks++; if (speed_lvl !== 2'd1) begin n_fail++; $display("FAIL midrst_speed got=%0d exp=1", speed_lvl); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL midrst_paused got=%0b exp=0", paused); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got=%0b exp=0", tick); end
    rst_n = 1'b1;
    wait_tick(0, 100, w);
    n_checks++; if (w != 32 || addr !== 8'd1) begin n_fail++; $display("FAIL midrst_first_tick got addr=%0d wait=%0d exp addr=1 wait=32", addr, w); end
    $display("mid-run reset: first tick after %0d clocks, addr=%0d", w, addr);
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_pause();
    test_speed();
    test_bounce();
    test_simul_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
